// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory bus responder: command encodings,
// FSM state type and parameter defaults.
package mem_bus_responder_pkg;

    typedef enum logic [1:0] {
        MEMIO_NOP   = 2'b00,
        MEMIO_READ  = 2'b01,
        MEMIO_WRITE = 2'b10,
        MEMIO_REG   = 2'b11
    } memio_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int DEPTH_DEFAULT       = 256;
    localparam int WAIT_CYCLES_DEFAULT = 2;

    function automatic logic is_access(input memio_e cmd);
        return (cmd == MEMIO_READ) || (cmd == MEMIO_WRITE);
    endfunction

endpackage

// File: rtl/mem_bus_responder_ram.sv
// DEPTH x 32 single-port word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_word_ram
    import mem_bus_responder_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [DEPTH];

    // Word write on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// Single-outstanding memory responder: accepts read/write in IDLE, waits
// WAIT_CYCLES cycles, then gives a one-cycle registered completion.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [1:0]  MemIO,
    input  logic [31:0] ALUAddr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        ValidMemData,
    output logic        Busy,
    output logic        MemErr
);

    localparam int         ADDR_W    = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    memio_e      cmd_r, cmd_next_s;
    logic [31:0] addr_r, addr_next_s;
    logic [31:0] wdata_r, wdata_next_s;
    memio_e      cmd_in_s;
    logic        in_range_s;
    logic        ram_we_s;
    logic        enter_resp_s;
    logic [31:0] ram_rdata_s;
    logic [31:0] rd_data_r;
    logic        valid_r, busy_r, err_r;

    assign cmd_in_s = memio_e'(MemIO);

    // Next-state, wait counter and request latch logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        cmd_next_s   = cmd_r;
        addr_next_s  = addr_r;
        wdata_next_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (is_access(cmd_in_s)) begin
                    cmd_next_s   = cmd_in_s;
                    addr_next_s  = ALUAddr;
                    wdata_next_s = WrData;
                    cnt_next_s   = WAIT_LOAD;
                    state_next_s = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
                cmd_next_s   = MEMIO_NOP;
            end
        endcase
    end

    // The *_next_s request fields cover both the zero-wait (straight from the
    // inputs) and the waited (from the latch) path into RESP.
    assign enter_resp_s = (state_next_s == ST_RESP) && (state_r != ST_RESP);
    assign in_range_s   = (addr_next_s < 32'(DEPTH));
    assign ram_we_s     = Rst_n && enter_resp_s && (cmd_next_s == MEMIO_WRITE) && in_range_s;

    mem_word_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we_s),
        .addr  (addr_next_s[ADDR_W-1:0]),
        .wdata (wdata_next_s),
        .rdata (ram_rdata_s)
    );

    // State and request registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            cmd_r   <= MEMIO_NOP;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            cmd_r   <= cmd_next_s;
            addr_r  <= addr_next_s;
            wdata_r <= wdata_next_s;
        end
    end

    // Registered response outputs, computed from the state being entered.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            rd_data_r <= 32'd0;
        end else begin
            busy_r    <= (state_next_s != ST_IDLE);
            valid_r   <= enter_resp_s;
            err_r     <= enter_resp_s && !in_range_s;
            rd_data_r <= (enter_resp_s && (cmd_next_s == MEMIO_READ) && in_range_s)
                         ? ram_rdata_s : 32'd0;
        end
    end

    assign RdData       = rd_data_r;
    assign ValidMemData = valid_r;
    assign Busy         = busy_r;
    assign MemErr       = err_r;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: one responder with two wait states and one with none,
// sharing clock and reset.
module tb_mem_bus_responder;
    import mem_bus_responder_pkg::*;

    logic        Clk;
    logic        Rst_n;
    logic [1:0]  memio2, memio0;
    logic [31:0] addr2, addr0, wdata2, wdata0;
    logic [31:0] rd2, rd0;
    logic        valid2, valid0, busy2, busy0, err2, err0;

    int checks = 0;
    int errors = 0;

    mem_bus_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .MemIO(memio2), .ALUAddr(addr2), .WrData(wdata2),
        .RdData(rd2), .ValidMemData(valid2), .Busy(busy2), .MemErr(err2)
    );

    mem_bus_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .MemIO(memio0), .ALUAddr(addr0), .WrData(wdata0),
        .RdData(rd0), .ValidMemData(valid0), .Busy(busy0), .MemErr(err0)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_in(input bit z, input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] d);
        if (z) begin
            memio0 = cmd; addr0 = a; wdata0 = d;
        end else begin
            memio2 = cmd; addr2 = a; wdata2 = d;
        end
    endtask

    // One complete access; z selects the zero-wait instance.
    task automatic txn(input bit z, input logic [1:0] cmd, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd,
                       input logic exp_err, input string tag);
        int lat;
        lat = z ? 1 : 3;
        set_in(z, cmd, a, d);
        step();
        set_in(z, MEMIO_NOP, 32'd0, 32'd0);
        for (int c = 1; c <= lat; c++) begin
            chk({tag, "_busy"},  {31'd0, z ? busy0 : busy2}, 32'd1);
            chk({tag, "_valid"}, {31'd0, z ? valid0 : valid2}, (c == lat) ? 32'd1 : 32'd0);
            if (c < lat) step();
        end
        chk({tag, "_rd"},  z ? rd0 : rd2, exp_rd);
        chk({tag, "_err"}, {31'd0, z ? err0 : err2}, {31'd0, exp_err});
        step();
        chk({tag, "_idle_busy"},  {31'd0, z ? busy0 : busy2}, 32'd0);
        chk({tag, "_idle_valid"}, {31'd0, z ? valid0 : valid2}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"},    rd2, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid2}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy2}, 32'd0);
        chk({tag, "_err"},   {31'd0, err2}, 32'd0);
    endtask

    initial begin
        Rst_n = 1'b0;
        set_in(1'b0, MEMIO_NOP, 32'd0, 32'd0);
        set_in(1'b1, MEMIO_NOP, 32'd0, 32'd0);
        step();
        step();
        chk_zero("reset");
        Rst_n = 1'b1;

        // Preload, then write/read-back with two wait states.
        txn(1'b0, MEMIO_WRITE, 32'd0, 32'h0123_4567, 32'd0, 1'b0, "wr0");
        txn(1'b0, MEMIO_WRITE, 32'd3, 32'h3333_3333, 32'd0, 1'b0, "wr3");
        txn(1'b0, MEMIO_WRITE, 32'd8, 32'h8888_8888, 32'd0, 1'b0, "wr8");
        txn(1'b0, MEMIO_WRITE, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, "wr5");
        txn(1'b0, MEMIO_READ,  32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, "rd5");

        // Out-of-range accesses must not alias onto address 0.
        txn(1'b0, MEMIO_READ,  32'd256, 32'd0, 32'd0, 1'b1, "oor_rd");
        txn(1'b0, MEMIO_WRITE, 32'd256, 32'hFFFF_FFFF, 32'd0, 1'b1, "oor_wr");
        txn(1'b0, MEMIO_READ,  32'd0, 32'd0, 32'h0123_4567, 1'b0, "rd0_after_oor");

        // Inputs changing while busy are ignored.
        set_in(1'b0, MEMIO_WRITE, 32'd7, 32'h7777_7777);
        step();
        set_in(1'b0, MEMIO_WRITE, 32'd8, 32'h0000_1234);
        chk("ign_busy1", {31'd0, busy2}, 32'd1);
        chk("ign_valid1", {31'd0, valid2}, 32'd0);
        step();
        chk("ign_busy2", {31'd0, busy2}, 32'd1);
        step();
        chk("ign_busy3", {31'd0, busy2}, 32'd1);
        chk("ign_valid3", {31'd0, valid2}, 32'd1);
        set_in(1'b0, MEMIO_NOP, 32'd0, 32'd0);
        step();
        chk("ign_busy_end", {31'd0, busy2}, 32'd0);
        txn(1'b0, MEMIO_READ, 32'd8, 32'd0, 32'h8888_8888, 1'b0, "rd8");
        txn(1'b0, MEMIO_READ, 32'd7, 32'd0, 32'h7777_7777, 1'b0, "rd7");

        // Reset in the middle of a write's wait period.
        set_in(1'b0, MEMIO_WRITE, 32'd3, 32'hAAAA_5555);
        step();
        set_in(1'b0, MEMIO_NOP, 32'd0, 32'd0);
        chk("rst_pre_busy", {31'd0, busy2}, 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        step();
        Rst_n = 1'b1;
        txn(1'b0, MEMIO_READ, 32'd3, 32'd0, 32'h3333_3333, 1'b0, "rd3_after_rst");

        // Register write-back command is ignored.
        set_in(1'b0, MEMIO_REG, 32'd0, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reg_busy", {31'd0, busy2}, 32'd0);
            chk("reg_valid", {31'd0, valid2}, 32'd0);
        end
        set_in(1'b0, MEMIO_NOP, 32'd0, 32'd0);
        txn(1'b0, MEMIO_READ, 32'd0, 32'd0, 32'h0123_4567, 1'b0, "rd0_after_reg");

        // Zero wait states: one-cycle latency, back-to-back reads.
        txn(1'b1, MEMIO_WRITE, 32'd1, 32'h1111_1111, 32'd0, 1'b0, "z_wr1");
        txn(1'b1, MEMIO_WRITE, 32'd2, 32'h2222_2222, 32'd0, 1'b0, "z_wr2");
        txn(1'b1, MEMIO_READ,  32'd1, 32'd0, 32'h1111_1111, 1'b0, "z_rd1");
        txn(1'b1, MEMIO_READ,  32'd2, 32'd0, 32'h2222_2222, 1'b0, "z_rd2");
        txn(1'b1, MEMIO_READ,  32'd300, 32'd0, 32'd0, 1'b1, "z_oor");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
